// File: rtl/pll_recfg_seq.sv
// pll_recfg_seq: retunes the memory-test PLL through the pll_cfg management
// port. On start it latches the M/K/C0 words, issues the fixed 8-write
// reconfiguration sequence, pulses pll_reset, then waits for pll_locked.
// Optional build macro RECFG_LOCK_TIMEOUT_EN adds a lock timeout (err flag).
module pll_recfg_seq #(
  parameter int unsigned GAP_CYCLES   = 7,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_reset
);

  typedef enum logic [2:0] {IDLE, WR, GAP, RST, LOCK, FIN} state_t;

  // Last cycle index of each timed phase; the shared counter restarts at 0
  // on entry to every phase.
  localparam logic [31:0] GAP_LAST    = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [31:0] RST_LAST    = (RST_CYCLES > 0) ? 32'(RST_CYCLES - 1) : 32'd0;
  // pll_locked lags the reset release, so it is ignored for this many cycles.
  localparam logic [31:0] LOCK_IGNORE = 32'd2;
`ifdef RECFG_LOCK_TIMEOUT_EN
  localparam logic [31:0] TO_LAST     = (LOCK_TIMEOUT > 0) ? 32'(LOCK_TIMEOUT - 1) : 32'd0;
`endif

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic [31:0] m_q, m_d;
  logic [31:0] k_q, k_d;
  logic [31:0] c_q, c_d;
`ifdef RECFG_LOCK_TIMEOUT_EN
  logic        err_q, err_d;
`endif

  // Saturating increment: long lock waits must never wrap the timer.
  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // State, index, timer and latched configuration words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

`ifdef RECFG_LOCK_TIMEOUT_EN
  // Sticky lock-timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state logic; a start in any state (re)launches the sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_inc;
    m_d     = m_q;
    k_d     = k_q;
    c_d     = c_q;
`ifdef RECFG_LOCK_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      WR: begin
        if (!mgmt_waitrequest) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = RST;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = (GAP_CYCLES == 0) ? WR : GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = WR;
          cnt_d   = '0;
        end
      end
      RST: begin
        if (cnt_q >= RST_LAST) begin
          state_d = LOCK;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (cnt_q >= LOCK_IGNORE && pll_locked) begin
          state_d = FIN;
        end
`ifdef RECFG_LOCK_TIMEOUT_EN
        else if (cnt_q >= TO_LAST) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = WR;
      idx_d   = '0;
      cnt_d   = '0;
      m_d     = m_val;
      k_d     = k_val;
      c_d     = c_val;
`ifdef RECFG_LOCK_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end
  end

  // Write table: address/data for the current index while in WR.
  always_comb begin
    mgmt_address   = '0;
    mgmt_writedata = '0;
    if (state_q == WR) begin
      case (idx_q)
        3'd0: begin mgmt_address = 6'd0; mgmt_writedata = 32'h0;         end
        3'd1: begin mgmt_address = 6'd4; mgmt_writedata = m_q;           end
        3'd2: begin mgmt_address = 6'd7; mgmt_writedata = k_q;           end
        3'd3: begin mgmt_address = 6'd3; mgmt_writedata = 32'h0001_0000; end
        3'd4: begin mgmt_address = 6'd5; mgmt_writedata = c_q;           end
        3'd5: begin mgmt_address = 6'd9; mgmt_writedata = 32'h1;         end
        3'd6: begin mgmt_address = 6'd8; mgmt_writedata = 32'h7;         end
        default: begin mgmt_address = 6'd2; mgmt_writedata = 32'h0;      end
      endcase
    end
  end

  // A restart drops any pending write and releases pll_reset in the same cycle.
  assign mgmt_write = (state_q == WR)  && !start;
  assign pll_reset  = (state_q == RST) && !start;
  assign busy       = (state_q == WR) || (state_q == GAP) ||
                      (state_q == RST) || (state_q == LOCK);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Scoreboard bench for pll_recfg_seq: stimulus pushes the expected write list
// and done/err outcome; a negedge monitor pops and compares on each accepted
// write and each done pulse.
module tb_pll_recfg_seq;

  localparam int GAP  = 7;
  localparam int RSTC = 8;
  localparam int TO   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] m_val = '0;
  logic [31:0] k_val = '0;
  logic [31:0] c_val = '0;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic        pll_reset;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic rand_wr_en = 1'b0;
  logic wr_force   = 1'b0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_q[$];
  logic exp_done_q[$];
  logic [5:0] atab [8] = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};

  int   acc_n = 0, wr_hi_n = 0, rst_hi_n = 0, done_n = 0, done_cyc = 0;
  int   acc_cyc[$];
  logic prev_rst = 1'b0;

  pll_recfg_seq #(
    .GAP_CYCLES  (GAP),
    .RST_CYCLES  (RSTC),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .m_val           (m_val),
    .k_val           (k_val),
    .c_val           (c_val),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_write      (mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked      (pll_locked),
    .pll_reset       (pll_reset)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream stall generator: random or forced by the stimulus.
  always @(posedge clk) begin
    #2;
    mgmt_waitrequest = rand_wr_en ? ($urandom_range(0, 3) == 0) : wr_force;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return mgmt_write;
      2:       return done;
      default: return busy;
    endcase
  endfunction

  // Bounded wait (sampled on negedges) for a DUT output to reach a value.
  task automatic wait_for(input int sel, input logic val, input int lim, input string nm);
    int   t;
    logic s;
    t = 0;
    do begin
      @(negedge clk);
      s = sig(sel);
      t++;
    end while (s !== val && t < lim);
    chk({nm, "_reached"}, 32'(s === val), 32'd1);
  endtask

  // Monitor: scoreboard pops on accepted writes and on done pulses.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n) begin
      if (mgmt_write) wr_hi_n++;
      if (pll_reset) rst_hi_n++;
      prev_rst = pll_reset;
      if (mgmt_write && !mgmt_waitrequest) begin
        acc_n++;
        acc_cyc.push_back(cyc);
        $display("write addr=%0d data=%h cyc=%0d", mgmt_address, mgmt_writedata, cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mgmt_address, mgmt_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mgmt_address), 32'(e.a));
          chk("wr_data", mgmt_writedata, e.d);
        end
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        $display("done err=%0b cyc=%0d", err, cyc);
        chk("busy_on_done", 32'(busy), 32'd0);
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required done=0");
        end else begin
          chk("done_err", 32'(err), 32'(exp_done_q.pop_front()));
        end
      end
    end else begin
      prev_rst = 1'b0;
    end
  end

  task automatic clear_logs();
    acc_n = 0; wr_hi_n = 0; rst_hi_n = 0; done_n = 0; done_cyc = 0;
    acc_cyc.delete();
  endtask

  // Issue a start; the reference model is the 8-entry write list built from
  // the sampled words. Inputs are scrambled right after the start cycle.
  task automatic issue_start(input logic [31:0] m, input logic [31:0] k,
                             input logic [31:0] c, input logic exp_err);
    logic [31:0] dtab [8];
    @(posedge clk); #1;
    m_val = m; k_val = k; c_val = c; start = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    dtab = '{32'h0, m, k, 32'h0001_0000, c, 32'h1, 32'h7, 32'h0};
    for (int i = 0; i < 8; i++) exp_q.push_back({atab[i], dtab[i]});
    exp_done_q.push_back(exp_err);
    $display("start m=%h k=%h c=%h", m, k, c);
    @(negedge clk);
    chk("start_cycle_write", 32'(mgmt_write), 32'd0);
    chk("start_cycle_pll_reset", 32'(pll_reset), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    m_val = $urandom; k_val = $urandom; c_val = $urandom;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
  endtask

  // Wait through RST, make pll_locked visible d cycles into LOCK (d=0: the
  // caller already holds it high), and check the done latency.
  task automatic finish_seq(input int d);
    int l_cyc, expd;
    wait_for(0, 1'b1, 3000, "rst_rise");
    wait_for(0, 1'b0, RSTC + 5, "rst_fall");
    l_cyc = cyc;
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1 pll_locked = 1'b1;
    end
    wait_for(2, 1'b1, 300, "done");
    expd = ((d < 2) ? 2 : d) + 1;
    chk("lock_to_done", 32'(cyc - l_cyc), 32'(expd));
    chk("rst_len", 32'(rst_hi_n), 32'(RSTC));
    @(posedge clk); #1 pll_locked = 1'b0;
  endtask

  task automatic end_checks();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("pending_done", 32'(exp_done_q.size()), 32'd0);
    chk("done_count", 32'(done_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s1, t, l_cyc;
    logic abort;

    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_write", 32'(mgmt_write), 32'd0);
    chk("rst_addr", 32'(mgmt_address), 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
    chk("rst_pll_reset", 32'(pll_reset), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: nominal sequence, no stalls, strobe spacing and counts
    clear_logs();
    issue_start(32'h167, 32'h808, 32'h20302, 1'b0);
    finish_seq(5);
    chk("n_writes", 32'(acc_n), 32'd8);
    chk("write_hi_cycles", 32'(wr_hi_n), 32'd8);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("strobe_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(GAP + 1));
    end_checks();

    // 2: 10-cycle stall on index 2
    clear_logs();
    issue_start(32'h167, 32'h808, 32'h20302, 1'b0);
    for (t = 0; t < 500 && acc_n < 2; t++) @(negedge clk);
    chk("reach_idx2", 32'(acc_n), 32'd2);
    @(posedge clk); #1 wr_force = 1'b1;
    wait_for(1, 1'b1, 50, "stall_write");
    s1 = cyc;
    for (int i = 0; i < 10; i++) begin
      chk("stall_write_held", 32'(mgmt_write), 32'd1);
      chk("stall_addr", 32'(mgmt_address), 32'd7);
      chk("stall_data", mgmt_writedata, 32'h808);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk); #1 wr_force = 1'b0;
    finish_seq(5);
    chk("stall_n_writes", 32'(acc_n), 32'd8);
    if (acc_cyc.size() > 2) chk("stall_accept_cycle", 32'(acc_cyc[2] - s1), 32'd10);
    chk("stall_write_hi_cycles", 32'(wr_hi_n), 32'd18);
    end_checks();

    // 3: restart while index 4 is stalled
    clear_logs();
    issue_start($urandom, $urandom, $urandom, 1'b0);
    for (t = 0; t < 500 && acc_n < 4; t++) @(negedge clk);
    chk("reach_idx4", 32'(acc_n), 32'd4);
    @(posedge clk); #1 wr_force = 1'b1;
    wait_for(1, 1'b1, 50, "stall_idx4");
    chk("idx4_addr", 32'(mgmt_address), 32'd5);
    issue_start(32'h70, $urandom, $urandom, 1'b0);
    wr_force = 1'b0;
    finish_seq(5);
    end_checks();

    // 3b: restart during RST
    clear_logs();
    issue_start($urandom, $urandom, $urandom, 1'b0);
    wait_for(0, 1'b1, 3000, "rst_rise_abort");
    issue_start($urandom, $urandom, $urandom, 1'b0);
    rst_hi_n = 0;
    done_n = 0;
    finish_seq(5);
    end_checks();

    // 4: asynchronous reset during RST
    clear_logs();
    issue_start($urandom, $urandom, $urandom, 1'b0);
    wait_for(0, 1'b1, 3000, "rst_rise_arst");
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_pll_reset", 32'(pll_reset), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_write", 32'(mgmt_write), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    exp_q.delete();
    exp_done_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_arst_busy", 32'(busy), 32'd0);
    chk("post_arst_err", 32'(err), 32'd0);
    chk("post_arst_writes", 32'(acc_n), 32'd8);
    chk("post_arst_done", 32'(done_n), 32'd0);

    // 5: lock never arrives
    clear_logs();
    pll_locked = 1'b0;
`ifdef RECFG_LOCK_TIMEOUT_EN
    issue_start($urandom, $urandom, $urandom, 1'b1);
    wait_for(0, 1'b1, 3000, "rst_rise_to");
    wait_for(0, 1'b0, RSTC + 5, "rst_fall_to");
    l_cyc = cyc;
    wait_for(2, 1'b1, TO + 20, "timeout_done");
    chk("timeout_latency", 32'(cyc - l_cyc), 32'(TO));
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("busy_after_timeout", 32'(busy), 32'd0);
    end_checks();
    clear_logs();
    issue_start($urandom, $urandom, $urandom, 1'b0);
    finish_seq(5);
    end_checks();
`else
    issue_start($urandom, $urandom, $urandom, 1'b0);
    wait_for(0, 1'b1, 3000, "rst_rise_nolock");
    wait_for(0, 1'b0, RSTC + 5, "rst_fall_nolock");
    repeat (150) @(negedge clk);
    chk("nolock_no_done", 32'(done_n), 32'd0);
    chk("nolock_busy", 32'(busy), 32'd1);
    chk("nolock_err", 32'(err), 32'd0);
    @(posedge clk); #1 pll_locked = 1'b1;
    wait_for(2, 1'b1, 10, "late_lock_done");
    @(posedge clk); #1 pll_locked = 1'b0;
    end_checks();
`endif

    // 6: randomized words, stalls, lock timing and occasional restarts
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      rand_wr_en = 1'b1;
      pll_locked = it[0];
      abort = ($urandom_range(0, 1) == 1);
      issue_start($urandom, $urandom, $urandom, 1'b0);
      if (abort) begin
        repeat ($urandom_range(2, 30)) @(posedge clk);
        issue_start($urandom, $urandom, $urandom, 1'b0);
      end
      finish_seq(pll_locked ? 0 : int'($urandom_range(1, 6)));
      rand_wr_en = 1'b0;
      repeat (3) @(posedge clk);
      end_checks();
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_recfg_seq.md
Name: pll_recfg_seq

Overview:
- Sequencer that drives the PLL reconfiguration management port (pll_cfg mgmt_* bus) to retune the memory-test clock.
- Given M, K and C0 words, it issues the fixed 8-write reconfiguration sequence, pulses the PLL reset, then waits for lock.
- Sits between the frequency-selection/key-handling logic (upstream, supplies start and the cfg words) and pll_cfg/pll (downstream).
- Replaces the inline state counter in the top level.

Parameters:
- GAP_CYCLES, 7: idle cycles between accepted writes; valid range 0..255.
- RST_CYCLES, 8: cycles pll_reset is held high; valid range 1..255.
- LOCK_TIMEOUT, 50000000: cycles allowed for lock before error. Used only with RECFG_LOCK_TIMEOUT_EN.

Ports:
- clk  in  1  management clock (CLK_50M domain).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; samples m_val, k_val, c_val.
- m_val  in  32  M counter word.
- k_val  in  32  fractional K word.
- c_val  in  32  C0 counter word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the sequence completes.
- err  out  1  sticky lock-timeout flag; cleared by start.
- mgmt_address  out  6  Avalon-MM address.
- mgmt_writedata  out  32  Avalon-MM write data.
- mgmt_write  out  1  Avalon-MM write strobe.
- mgmt_waitrequest  in  1  Avalon-MM stall.
- pll_locked  in  1  PLL lock, already synchronous to clk.
- pll_reset  out  1  PLL reset request, active high.

Behaviour:
- Reset values: busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, pll_reset=0. State is IDLE and the write index is 0.
- States:
  - IDLE
  - WR (index 0..7)
  - GAP
  - RST
  - LOCK
  - FIN
- Write table, as index: address, data:
  - 0: addr 0, data 0 (mode)
  - 1: addr 4, data m_val
  - 2: addr 7, data k_val
  - 3: addr 3, data 32'h0001_0000 (N bypass)
  - 4: addr 5, data c_val
  - 5: addr 9, data 1 (charge pump)
  - 6: addr 8, data 7 (bandwidth)
  - 7: addr 2, data 0 (apply)
- m_val, k_val and c_val are latched on the start cycle. Later changes to the inputs have no effect on a running sequence.
- IDLE: when start=1, latch the inputs, clear err, set index=0 and go to WR. busy rises the next cycle.
- WR:
  - mgmt_write=1 with the address and data of the current index.
  - Address, data and write are held stable while mgmt_waitrequest=1.
  - The write is accepted on the first cycle with mgmt_write=1 and mgmt_waitrequest=0. mgmt_write deasserts the following cycle.
  - After acceptance: if index<7, increment index and go to GAP. If index==7, go to RST.
- GAP: count GAP_CYCLES cycles, then return to WR. With GAP_CYCLES=0, the next write is asserted the cycle after acceptance.
- RST: pll_reset=1 for exactly RST_CYCLES cycles, then deasserted. Go to LOCK.
- LOCK:
  - Ignore pll_locked during the first 2 cycles (the lock output lags the reset).
  - From then on, pll_locked=1 goes to FIN.
- FIN: done=1 for one cycle and busy=0 on that same cycle. Return to IDLE.
- start while busy: abort and restart from index 0 with the newly latched inputs.
  - If mgmt_write is high and not yet accepted, it is dropped and the write does not complete.
  - pll_reset is deasserted immediately.
  - No done pulse is produced for the aborted sequence.
- start on the FIN cycle: done still pulses, and the new sequence starts as from IDLE.
- rst_n low mid-sequence: all outputs return to reset values asynchronously, and the partial configuration is abandoned.
- pll_locked is not checked before or during the writes. Only LOCK samples it.
- Counters saturate, never wrap; the lock timer is 32 bits.

Optional Feature:
- Macro: RECFG_LOCK_TIMEOUT_EN.
- Defined:
  - LOCK counts cycles. If LOCK_TIMEOUT cycles pass without lock, set err=1, pulse done and go to IDLE.
  - err stays high until the next start or reset.
- Undefined:
  - LOCK waits indefinitely and err is tied to 0.
  - The LOCK_TIMEOUT parameter is unused.

Test Plan:
- GAP_CYCLES=7, waitrequest=0, start with m=32'h167, k=32'h808, c=32'h20302:
  - Exactly 8 write strobes, each 1 cycle, with 7 idle cycles between strobes.
  - Address order 0,4,7,3,5,9,8,2.
  - Data order 0, 32'h167, 32'h808, 32'h10000, 32'h20302, 1, 7, 0.
  - Then pll_reset high for 8 cycles.
  - pll_locked raised 5 cycles later: done pulses once and busy drops in the same cycle.
- waitrequest held high for 10 cycles on write index 2 (addr 7, data 32'h808):
  - mgmt_write, address and data stable for all 10 cycles.
  - Acceptance on the 11th cycle, no duplicate write.
- start re-pulsed while index 4 is stalled, with m=32'h70:
  - The sequence restarts at addr 0.
  - The second write carries 32'h70.
  - Only one done pulse in total.
- rst_n asserted during RST:
  - pll_reset, busy and mgmt_write go to 0 in the same cycle, before any clock edge.
  - After release the block is in IDLE with err=0.
- RECFG_LOCK_TIMEOUT_EN defined, LOCK_TIMEOUT=100, pll_locked held 0:
  - err=1 and done pulses 100 cycles after entry to LOCK.
  - A following start clears err.
- Inputs m_val, k_val and c_val changed the cycle after start: the writes still carry the values latched on the start cycle.
